adxl355_seq_ctrl: RTL

- Sequences the SPI master for the ADXL355 accelerometer: one-time configuration writes, then periodic 9-byte burst reads of XDATA3..ZDATA1.
- Drives the SPI master's request side (cs_n_in, wr_rd, address, write data) and consumes its byte strobe (data_out_vld, data_out).
- Assembles three signed 20-bit axis samples and publishes them with a one-cycle valid pulse to downstream filter/UART logic.

---
 rtl/adxl355_seq_ctrl.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/adxl355_seq_ctrl.sv
// ADXL355 sequencer: RANGE/POWER_CTL config writes, then periodic 9-byte burst reads of XDATA3..ZDATA1.
// Define ADXL355_ID_CHECK_EN to read and verify DEVID_AD (0xAD) before configuring.
module adxl355_seq_ctrl #(
  parameter int         BIT_CLKS      = 40,
  parameter int         CS_GAP        = 20,
  parameter int         START_DLY     = 1000,
  parameter int         SAMPLE_PERIOD = 100000,
  parameter logic [7:0] RANGE_VAL     = 8'h01,
  parameter logic [7:0] PWR_VAL       = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        cs_n_in,
  output logic        wr_rd,
  output logic [6:0]  spi_addr_master,
  output logic [7:0]  spi_data_master,
  input  logic        data_out_vld,
  input  logic [7:0]  data_out,
  output logic [19:0] x_data,
  output logic [19:0] y_data,
  output logic [19:0] z_data,
  output logic        sample_vld,
  output logic        cfg_done,
  output logic        busy,
  output logic        err,
  output logic        overrun
);

  localparam int WR_CLKS = 16 * BIT_CLKS;
  localparam int TO_CLKS = (8 + 72 + 4) * BIT_CLKS;
  localparam int MAX_A   = (START_DLY > TO_CLKS) ? START_DLY : TO_CLKS;
  localparam int CNT_MAX = (MAX_A > CS_GAP) ? MAX_A : CS_GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int PW      = $clog2(SAMPLE_PERIOD + 1);

  localparam logic [CW-1:0] BOOT_LAST = CW'(START_DLY - 1);
  localparam logic [CW-1:0] WR_LAST   = CW'(WR_CLKS - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(CS_GAP - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TO_CLKS - 1);
  localparam logic [PW-1:0] PER_LAST  = PW'(SAMPLE_PERIOD - 1);

  localparam logic [6:0] ADDR_RANGE  = 7'h2C;
  localparam logic [6:0] ADDR_PWR    = 7'h2D;
  localparam logic [6:0] ADDR_XDATA3 = 7'h08;

  localparam logic [3:0] S_BOOT     = 4'd0;
  localparam logic [3:0] S_WR_RANGE = 4'd1;
  localparam logic [3:0] S_GAP1     = 4'd2;
  localparam logic [3:0] S_WR_PWR   = 4'd3;
  localparam logic [3:0] S_GAP2     = 4'd4;
  localparam logic [3:0] S_WAIT     = 4'd5;
  localparam logic [3:0] S_RD_BURST = 4'd6;
  localparam logic [3:0] S_GAP3     = 4'd7;
`ifdef ADXL355_ID_CHECK_EN
  localparam logic [3:0] S_RD_ID    = 4'd8;
  localparam logic [3:0] S_GAP_ID   = 4'd9;
  localparam logic [3:0] S_ERR      = 4'd10;
  localparam logic [6:0] ADDR_DEVID = 7'h00;
  localparam logic [7:0] DEVID_VAL  = 8'hAD;
`endif

  logic [3:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    byte_idx, byte_nxt;
  logic [PW-1:0] per_cnt;
  logic          tick;
  logic          cs_n_nxt, wr_rd_nxt, cfg_done_nxt, err_nxt;
  logic [6:0]    addr_nxt;
  logic [7:0]    wdata_nxt;
  logic          burst_done;
  logic [19:0]   x_acc, y_acc;
  logic [15:0]   z_acc;

  assign tick       = cfg_done && (per_cnt == PER_LAST);
  assign burst_done = (state == S_RD_BURST) && data_out_vld && (byte_idx == 4'd8);

  always_comb begin
    // NOTE: every combinational output is defaulted first so no path can infer a latch.
    state_nxt    = state;
    cnt_nxt      = cnt + 1'b1;
    byte_nxt     = byte_idx;
    cs_n_nxt     = cs_n_in;
    wr_rd_nxt    = wr_rd;
    addr_nxt     = spi_addr_master;
    wdata_nxt    = spi_data_master;
    cfg_done_nxt = cfg_done;
    err_nxt      = err;
    case (state)
      S_BOOT: begin
        if (cnt == BOOT_LAST) begin
          cnt_nxt   = '0;
          cs_n_nxt  = 1'b0;
`ifdef ADXL355_ID_CHECK_EN
          state_nxt = S_RD_ID;
          wr_rd_nxt = 1'b1;
          addr_nxt  = ADDR_DEVID;
          wdata_nxt = 8'h00;
`else
          state_nxt = S_WR_RANGE;
          wr_rd_nxt = 1'b0;
          addr_nxt  = ADDR_RANGE;
          wdata_nxt = RANGE_VAL;
`endif
        end
      end
`ifdef ADXL355_ID_CHECK_EN
      S_RD_ID: begin
        if (data_out_vld) begin
          cs_n_nxt  = 1'b1;
          cnt_nxt   = '0;
          if (data_out == DEVID_VAL) state_nxt = S_GAP_ID;
          else begin
            state_nxt = S_ERR;
            err_nxt   = 1'b1;
          end
        end else if (cnt == TO_LAST) begin
          cs_n_nxt  = 1'b1;
          err_nxt   = 1'b1;
          state_nxt = S_ERR;
        end
      end
      S_GAP_ID: begin
        if (cnt == GAP_LAST) begin
          state_nxt = S_WR_RANGE;
          cnt_nxt   = '0;
          cs_n_nxt  = 1'b0;
          wr_rd_nxt = 1'b0;
          addr_nxt  = ADDR_RANGE;
          wdata_nxt = RANGE_VAL;
        end
      end
      S_ERR: cnt_nxt = '0;
`endif
      S_WR_RANGE, S_WR_PWR: begin
        if (cnt == WR_LAST) begin
          state_nxt = (state == S_WR_RANGE) ? S_GAP1 : S_GAP2;
          cnt_nxt   = '0;
          cs_n_nxt  = 1'b1;
        end
      end
      S_GAP1: begin
        if (cnt == GAP_LAST) begin
          state_nxt = S_WR_PWR;
          cnt_nxt   = '0;
          cs_n_nxt  = 1'b0;
          addr_nxt  = ADDR_PWR;
          wdata_nxt = PWR_VAL;
        end
      end
      S_GAP2: begin
        if (cnt == GAP_LAST) begin
          state_nxt    = S_WAIT;
          cnt_nxt      = '0;
          cfg_done_nxt = 1'b1;
        end
      end
      S_WAIT: begin
        cnt_nxt = '0;
        if (tick && en) begin
          state_nxt = S_RD_BURST;
          cs_n_nxt  = 1'b0;
          wr_rd_nxt = 1'b1;
          addr_nxt  = ADDR_XDATA3;
          wdata_nxt = 8'h00;
          byte_nxt  = '0;
        end
      end
      S_RD_BURST: begin
        if (data_out_vld) byte_nxt = byte_idx + 1'b1;
        // A strobe landing on the last timeout cycle still completes the burst.
        if (burst_done || cnt == TO_LAST) begin
          state_nxt = S_GAP3;
          cnt_nxt   = '0;
          cs_n_nxt  = 1'b1;
          err_nxt   = err | ~burst_done;
        end
      end
      S_GAP3: begin
        if (cnt == GAP_LAST) begin
          state_nxt = S_WAIT;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = S_BOOT;
        cnt_nxt   = '0;
        cs_n_nxt  = 1'b1;
      end
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_BOOT;
      cnt             <= '0;
      byte_idx        <= '0;
      cs_n_in         <= 1'b1;
      wr_rd           <= 1'b0;
      spi_addr_master <= '0;
      spi_data_master <= '0;
      x_data          <= '0;
      y_data          <= '0;
      z_data          <= '0;
      sample_vld      <= 1'b0;
      cfg_done        <= 1'b0;
      busy            <= 1'b0;
      err             <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      byte_idx        <= byte_nxt;
      cs_n_in         <= cs_n_nxt;
      busy            <= ~cs_n_nxt;
      wr_rd           <= wr_rd_nxt;
      spi_addr_master <= addr_nxt;
      spi_data_master <= wdata_nxt;
      cfg_done        <= cfg_done_nxt;
      err             <= err_nxt;
      sample_vld      <= burst_done;
      // Ticks outside S_WAIT are dropped; S_GAP3 still counts as busy.
      overrun         <= overrun | (tick & (state != S_WAIT));
      if (burst_done) begin
        x_data <= x_acc;
        y_data <= y_acc;
        z_data <= {z_acc, data_out[7:4]};
      end
    end
  end

  // Period timer is held at zero until configuration finishes, then free-runs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    per_cnt <= '0;
    else if (!cfg_done || tick) per_cnt <= '0;
    else                        per_cnt <= per_cnt + 1'b1;
  end

  // NOTE: the assembly shadows carry no reset; they are only published after all nine bytes are rewritten.
  always_ff @(posedge clk) begin
    if (state == S_RD_BURST && data_out_vld) begin
      case (byte_idx)
        4'd0:    x_acc[19:12] <= data_out;
        4'd1:    x_acc[11:4]  <= data_out;
        4'd2:    x_acc[3:0]   <= data_out[7:4];
        4'd3:    y_acc[19:12] <= data_out;
        4'd4:    y_acc[11:4]  <= data_out;
        4'd5:    y_acc[3:0]   <= data_out[7:4];
        4'd6:    z_acc[15:8]  <= data_out;
        4'd7:    z_acc[7:0]   <= data_out;
        default: ;
      endcase
    end
  end

endmodule
